pipe_sched: RTL and testbench
=============================

// Module: pipe_sched
// PURPOSE
// Sequencing controller for the 4-stage fetch/decode/execute/writeback core. Owns the run-mode FSM and the PC.
// Also owns the execute-latency counter and a 64-entry register scoreboard for RAW interlock.
// Emits the per-stage update codes (hold/advance/flush) that drive fdreg, dereg and ewreg.
// PARAMETERS
// RESET_PC   32'h0  PC value loaded on reset
// WAIT_W     5      width of per-op execute wait time
// PORTS
// clk         in   1       core clock
// rst         in   1       synchronous reset, active high
// ld_done     in   1       instruction loader finished filling instruction memory
// boot_ack    in   1       host boot handshake byte sent
// d_valid     in   1       decode stage holds a real instruction
// d_rs,d_rt   in   6       decode source register indices
// d_rs_use    in   1       d_rs is read by the instruction
// d_rt_use    in   1       d_rt is read by the instruction
// d_rd        in   6       decode destination register
// d_rw        in   1       decode instruction writes d_rd
// d_wait      in   WAIT_W  extra execute cycles needed by the decode instruction
// d_jump      in   1       decode instruction is j/jal/jr (target known one cycle after decode)
// d_npc       in   32      jump target from decode
// d_stop      in   1       decode instruction is halt
// e_busy      in   1       execute UART op still in progress
// redirect    in   1       writeback detected a mispredicted branch or jr
// redirect_pc in   32      corrected PC
// wb_valid    in   1       writeback writes the register file this cycle
// wb_rd       in   6       writeback destination
// mode        out  2       0 IDLE, 1 LOAD, 2 EXEC, 3 HALT
// pc          out  32      fetch PC
// fd_upd      out  2       fdreg update code: 00 hold, 01 advance, 10 flush
// de_upd      out  2       dereg update code, same encoding
// ew_upd      out  2       ewreg update code, same encoding
// e_start     out  1       one-cycle pulse: new op entered execute
// raw_stall   out  1       decode held by scoreboard
// BEHAVIOUR
// - Reset: mode=IDLE, pc=RESET_PC, lat=0, cur_wait=0, jb=0, scoreboard=0, e_start=0, all upd=10.
// - FSM: IDLE->LOAD on ld_done; LOAD->EXEC on boot_ack; EXEC->HALT when an advance issues an op with d_stop.
//   HALT is exit-only via rst.
// - Outside EXEC: all upd=10, pc frozen.
// - lat: counts cycles since the op entered execute; saturates at 2^WAIT_W-1.
// - cur_wait: latched from d_wait when the op issues.
// - exec_done = (lat >= cur_wait) && !e_busy.
// - raw_stall = d_valid && ((d_rs_use && sb[d_rs]) || (d_rt_use && sb[d_rt])).
//   A bit cleared by wb in the same cycle counts as free (bypass).
// - jump bubble: on the first cycle a d_jump op sits in decode, jb=0. That cycle is a hold, with pc<=d_npc and jb<=1.
//   jb clears on advance or redirect.
// - Per-cycle priority in EXEC:
//   1. redirect: all upd=10, pc<=redirect_pc, lat<=0, clear the sb bit set by the op currently in DE, jb<=0.
//   2. advance (exec_done && !raw_stall && !(d_jump && !jb)): all upd=01, pc<=pc+4 (unless jb already loaded pc).
//      Also lat<=0, cur_wait<=d_wait, e_start<=1, and if d_valid && d_rw then sb[d_rd]<=1.
//   3. otherwise: all upd=00, lat increments.
// - raw_stall with exec_done true inserts a bubble: fd_upd=00, de_upd=10, ew_upd=01, no sb set.
// - Scoreboard: wb_valid clears sb[wb_rd]. Same-cycle set and clear of one index: set wins. Register 0 is never set.
// - e_start is registered, high exactly one cycle per issued op.
// - Outputs are registered except the upd codes and raw_stall (combinational from state and inputs, no input->output loop via pc).
// CONFIGURATION
// - PIPE_SCHED_PERF_EN defined: adds outputs perf_cyc, perf_stall, perf_flush (32 each).
//   Reset to 0; count EXEC cycles, non-advance EXEC cycles and redirect cycles; wrap at 2^32.
// - PIPE_SCHED_PERF_EN undefined: ports and counters are absent; the rest of the behaviour is identical.
// TESTING
// - rst; ld_done@5; boot_ack@9 -> mode 0->1 at cycle 6, 1->2 at cycle 10; pc=0 and upd=10 until EXEC.
// - Op with d_wait=3 issued -> e_start pulse, then exactly 3 hold cycles, advance on 4th cycle, pc +4.
// - Issue rd=5 rw=1, next decode reads rs=5 -> raw_stall=1 and bubble injected until wb_valid rd=5.
//   Decode advances that same cycle.
// - d_jump with d_npc=0x100 -> one hold cycle, pc=0x100, next advance does not add 4.
// - redirect with redirect_pc=0x40 during a 3-cycle op -> all upd=10, pc=0x40, lat=0, sb bit of flushed DE op cleared.
// - d_stop issued -> mode=3 next cycle; all upd=10 thereafter; rst mid-EXEC returns every output to reset values in one cycle.

Source files
------------

// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - run-mode FSM, PC, execute latency and RAW scoreboard for the 4-stage core
// Optional performance counters are built in when PIPE_SCHED_PERF_EN is defined.
module pipe_sched #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          WAIT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_done,
    input  logic              boot_ack,
    input  logic              d_valid,
    input  logic [5:0]        d_rs,
    input  logic [5:0]        d_rt,
    input  logic              d_rs_use,
    input  logic              d_rt_use,
    input  logic [5:0]        d_rd,
    input  logic              d_rw,
    input  logic [WAIT_W-1:0] d_wait,
    input  logic              d_jump,
    input  logic [31:0]       d_npc,
    input  logic              d_stop,
    input  logic              e_busy,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              wb_valid,
    input  logic [5:0]        wb_rd,
    output logic [1:0]        mode,
    output logic [31:0]       pc,
    output logic [1:0]        fd_upd,
    output logic [1:0]        de_upd,
    output logic [1:0]        ew_upd,
    output logic              e_start,
`ifdef PIPE_SCHED_PERF_EN
    output logic [31:0]       perf_cyc,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush,
`endif
    output logic              raw_stall
);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_LOAD = 2'd1,
        M_EXEC = 2'd2,
        M_HALT = 2'd3
    } mode_t;

    localparam logic [1:0]        UPD_HOLD  = 2'b00;
    localparam logic [1:0]        UPD_ADV   = 2'b01;
    localparam logic [1:0]        UPD_FLUSH = 2'b10;
    localparam logic [WAIT_W-1:0] LAT_MAX   = '1;
    localparam logic [WAIT_W-1:0] LAT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};

    mode_t             state, state_nxt;
    logic [WAIT_W-1:0] lat, cur_wait;
    logic              jb;
    logic [63:0]       sb, sb_byp, sb_nxt;
    logic              de_sb_vld;
    logic [5:0]        de_sb_rd;

    logic in_exec, exec_done, jump_hold;
    logic do_redirect, do_advance, do_bubble;
    logic issue_wr, issue_stop;

    assign in_exec    = (state == M_EXEC);
    assign exec_done  = (lat >= cur_wait) && !e_busy;
    assign jump_hold  = d_jump && !jb;
    assign issue_wr   = d_valid && d_rw && (d_rd != 6'd0);
    assign issue_stop = d_valid && d_stop;

    // A register being written back this cycle already counts as free.
    always_comb begin
        sb_byp = sb;
        if (wb_valid)
            sb_byp[wb_rd] = 1'b0;
    end

    assign raw_stall = d_valid && ((d_rs_use && sb_byp[d_rs]) || (d_rt_use && sb_byp[d_rt]));

    assign do_redirect = in_exec && redirect;
    assign do_advance  = in_exec && !redirect && exec_done && !raw_stall && !jump_hold;
    assign do_bubble   = in_exec && !redirect && exec_done && raw_stall;

    always_ff @(posedge clk) begin
        if (rst)
            state <= M_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            M_IDLE:  if (ld_done)                   state_nxt = M_LOAD;
            M_LOAD:  if (boot_ack)                  state_nxt = M_EXEC;
            M_EXEC:  if (do_advance && issue_stop)  state_nxt = M_HALT;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        fd_upd = UPD_FLUSH;
        de_upd = UPD_FLUSH;
        ew_upd = UPD_FLUSH;
        if (in_exec && !redirect) begin
            if (do_advance) begin
                fd_upd = UPD_ADV;
                de_upd = UPD_ADV;
                ew_upd = UPD_ADV;
            end else if (do_bubble) begin
                fd_upd = UPD_HOLD;
                de_upd = UPD_FLUSH;
                ew_upd = UPD_ADV;
            end else begin
                fd_upd = UPD_HOLD;
                de_upd = UPD_HOLD;
                ew_upd = UPD_HOLD;
            end
        end
    end

    assign mode = state;

    // Set wins over any clear of the same index in the same cycle.
    always_comb begin
        sb_nxt = sb_byp;
        if (do_redirect && de_sb_vld)
            sb_nxt[de_sb_rd] = 1'b0;
        if (do_advance && issue_wr)
            sb_nxt[d_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            lat       <= '0;
            cur_wait  <= '0;
            jb        <= 1'b0;
            sb        <= '0;
            e_start   <= 1'b0;
            de_sb_vld <= 1'b0;
            de_sb_rd  <= 6'd0;
        end else begin
            sb      <= sb_nxt;
            e_start <= do_advance;
            if (do_redirect) begin
                pc        <= redirect_pc;
                lat       <= '0;
                jb        <= 1'b0;
                de_sb_vld <= 1'b0;
            end else if (do_advance) begin
                if (!jb)
                    pc <= pc + 32'd4;
                lat       <= '0;
                cur_wait  <= d_wait;
                jb        <= 1'b0;
                de_sb_vld <= issue_wr;
                de_sb_rd  <= d_rd;
            end else if (in_exec) begin
                if (lat != LAT_MAX)
                    lat <= lat + LAT_ONE;
                // Jump target is loaded during the bubble so the next advance fetches it.
                if (jump_hold) begin
                    pc <= d_npc;
                    jb <= 1'b1;
                end
                if (do_bubble)
                    de_sb_vld <= 1'b0;
            end
        end
    end

`ifdef PIPE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cyc   <= 32'd0;
            perf_stall <= 32'd0;
            perf_flush <= 32'd0;
        end else begin
            if (in_exec)
                perf_cyc <= perf_cyc + 32'd1;
            if (in_exec && !do_advance)
                perf_stall <= perf_stall + 32'd1;
            if (do_redirect)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// tb/tb_pipe_sched.sv - directed and randomized bench for pipe_sched against a behavioural model
module tb_pipe_sched;

    localparam int WAIT_W  = 5;
    localparam int LAT_MAX = (1 << WAIT_W) - 1;

    logic              clk, rst, ld_done, boot_ack, d_valid, d_rs_use, d_rt_use, d_rw;
    logic [5:0]        d_rs, d_rt, d_rd, wb_rd;
    logic [WAIT_W-1:0] d_wait;
    logic              d_jump, d_stop, e_busy, redirect, wb_valid;
    logic [31:0]       d_npc, redirect_pc;
    logic [1:0]        mode, fd_upd, de_upd, ew_upd;
    logic [31:0]       pc;
    logic              e_start, raw_stall;

    int checks = 0;
    int failures = 0;

    pipe_sched #(.RESET_PC(32'h0), .WAIT_W(WAIT_W)) dut (
        .clk(clk), .rst(rst), .ld_done(ld_done), .boot_ack(boot_ack),
        .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
        .d_rd(d_rd), .d_rw(d_rw), .d_wait(d_wait), .d_jump(d_jump), .d_npc(d_npc), .d_stop(d_stop),
        .e_busy(e_busy), .redirect(redirect), .redirect_pc(redirect_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .mode(mode), .pc(pc), .fd_upd(fd_upd), .de_upd(de_upd), .ew_upd(ew_upd),
        .e_start(e_start), .raw_stall(raw_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic clear_dec();
        d_valid = 0; d_rs = 0; d_rt = 0; d_rs_use = 0; d_rt_use = 0; d_rd = 0; d_rw = 0;
        d_wait = 0; d_jump = 0; d_npc = 0; d_stop = 0;
    endtask

    task automatic clear_all();
        clear_dec();
        ld_done = 0; boot_ack = 0; e_busy = 0; redirect = 0; redirect_pc = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: evaluated at each falling edge from the inputs held for this cycle.
    localparam int K_OFF = 0, K_RED = 1, K_ADV = 2, K_BUB = 3, K_HOLD = 4;
    int          m_mode, m_lat, m_wait, m_de_rd, kind;
    logic [31:0] m_pc;
    bit          m_jb, m_es, m_ok, e_raw, done;
    bit [63:0]   m_sb, sbv;
    logic [1:0]  ef, ed, ee;

    always @(negedge clk) begin
        if (m_ok) begin
            sbv = m_sb;
            if (wb_valid) sbv[wb_rd] = 1'b0;
            e_raw = d_valid && ((d_rs_use && sbv[d_rs]) || (d_rt_use && sbv[d_rt]));
            done  = (m_lat >= m_wait) && !e_busy;
            if (m_mode != 2)                          kind = K_OFF;
            else if (redirect)                        kind = K_RED;
            else if (done && e_raw)                   kind = K_BUB;
            else if (done && !(d_jump && !m_jb))      kind = K_ADV;
            else                                      kind = K_HOLD;
            case (kind)
                K_ADV:   begin ef = 2'b01; ed = 2'b01; ee = 2'b01; end
                K_BUB:   begin ef = 2'b00; ed = 2'b10; ee = 2'b01; end
                K_HOLD:  begin ef = 2'b00; ed = 2'b00; ee = 2'b00; end
                default: begin ef = 2'b10; ed = 2'b10; ee = 2'b10; end
            endcase
            chk("m_mode", 32'(mode), 32'(m_mode));
            chk("m_pc", pc, m_pc);
            chk("m_e_start", 32'(e_start), 32'(m_es));
            chk("m_raw_stall", 32'(raw_stall), 32'(e_raw));
            chk("m_fd_upd", 32'(fd_upd), 32'(ef));
            chk("m_de_upd", 32'(de_upd), 32'(ed));
            chk("m_ew_upd", 32'(ew_upd), 32'(ee));

            m_es = (kind == K_ADV);
            m_sb = sbv;
            if (m_mode == 0 && ld_done) m_mode = 1;
            else if (m_mode == 1 && boot_ack) m_mode = 2;
            case (kind)
                K_RED: begin
                    m_pc = redirect_pc; m_lat = 0; m_jb = 0;
                    if (m_de_rd > 0) m_sb[m_de_rd] = 1'b0;
                    m_de_rd = -1;
                end
                K_ADV: begin
                    if (!m_jb) m_pc = m_pc + 4;
                    m_lat = 0; m_wait = int'(d_wait); m_jb = 0;
                    if (d_valid && d_rw && d_rd != 0) begin
                        m_sb[d_rd] = 1'b1;
                        m_de_rd = int'(d_rd);
                    end else m_de_rd = -1;
                    if (d_valid && d_stop) m_mode = 3;
                end
                K_BUB, K_HOLD: begin
                    if (m_lat < LAT_MAX) m_lat++;
                    if (d_jump && !m_jb) begin m_pc = d_npc; m_jb = 1; end
                    if (kind == K_BUB) m_de_rd = -1;
                end
                default: ;
            endcase
        end
        if (rst) begin
            m_ok = 1; m_mode = 0; m_pc = 0; m_lat = 0; m_wait = 0; m_jb = 0;
            m_sb = 0; m_de_rd = -1; m_es = 0;
        end
    end

    bit found;

    initial begin
        m_ok = 0;
        clear_all();
        rst = 1;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_pc", pc, 0);
        chk("rst_fd_upd", 32'(fd_upd), 2);
        chk("rst_e_start", 32'(e_start), 0);

        tick(); ld_done = 1;
        @(negedge clk); chk("idle_mode", 32'(mode), 0);
        tick(); ld_done = 0;
        @(negedge clk); chk("load_mode", 32'(mode), 1); chk("load_de_upd", 32'(de_upd), 2); chk("load_pc", pc, 0);
        tick(); boot_ack = 1;
        @(negedge clk); chk("load_ew_upd", 32'(ew_upd), 2);
        tick(); boot_ack = 0;
        d_valid = 1; d_wait = 3;
        @(negedge clk); chk("exec_mode", 32'(mode), 2); chk("first_adv", 32'(fd_upd), 1); chk("first_pc", pc, 0);

        // Producer of r5 waits in decode while the 3-cycle op executes.
        tick(); clear_dec(); d_valid = 1; d_rd = 5; d_rw = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin chk("wait_estart", 32'(e_start), 1); chk("wait_pc", pc, 32'h4); end
            if (i == 1) chk("wait_estart_low", 32'(e_start), 0);
            chk("wait_hold", 32'(fd_upd), 0);
            tick();
        end
        @(negedge clk); chk("wait_adv", 32'(fd_upd), 1);

        tick(); clear_dec(); d_valid = 1; d_rs = 5; d_rs_use = 1;
        @(negedge clk);
        chk("raw_pc", pc, 32'h8); chk("raw_stall", 32'(raw_stall), 1);
        chk("bub_fd", 32'(fd_upd), 0); chk("bub_de", 32'(de_upd), 2); chk("bub_ew", 32'(ew_upd), 1);
        tick();
        @(negedge clk); chk("raw_stall2", 32'(raw_stall), 1);
        tick(); wb_valid = 1; wb_rd = 5;
        @(negedge clk); chk("raw_bypass", 32'(raw_stall), 0); chk("raw_release", 32'(fd_upd), 1);

        tick(); wb_valid = 0; clear_dec(); d_valid = 1; d_jump = 1; d_npc = 32'h100;
        @(negedge clk); chk("jump_pc0", pc, 32'hc); chk("jump_hold", 32'(fd_upd), 0);
        tick();
        @(negedge clk); chk("jump_pc", pc, 32'h100); chk("jump_adv", 32'(fd_upd), 1);
        tick(); clear_dec(); d_valid = 1; d_wait = 3; d_rd = 7; d_rw = 1;
        @(negedge clk); chk("jump_no_add", pc, 32'h100); chk("op7_adv", 32'(fd_upd), 1);
        tick(); clear_dec(); d_valid = 1; d_rs = 7; d_rs_use = 1;
        @(negedge clk); chk("op7_pc", pc, 32'h104); chk("op7_raw", 32'(raw_stall), 1); chk("op7_hold", 32'(de_upd), 0);
        tick(); redirect = 1; redirect_pc = 32'h40;
        @(negedge clk); chk("red_fd", 32'(fd_upd), 2); chk("red_de", 32'(de_upd), 2); chk("red_ew", 32'(ew_upd), 2);
        tick(); redirect = 0;
        @(negedge clk); chk("red_pc", pc, 32'h40); chk("red_sb_clr", 32'(raw_stall), 0); chk("red_lat", 32'(fd_upd), 0);

        tick(); clear_dec(); d_valid = 1; d_stop = 1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (fd_upd == 2'b01) found = 1;
            else tick();
        end
        chk("stop_adv_seen", 32'(found), 1);
        tick(); clear_dec();
        @(negedge clk); chk("halt_mode", 32'(mode), 3); chk("halt_upd", 32'(fd_upd), 2);

        // Mid-EXEC reset.
        tick(); rst = 1;
        tick(); rst = 0; ld_done = 1;
        tick(); ld_done = 0; boot_ack = 1;
        tick(); boot_ack = 0; d_valid = 1; d_wait = 2; d_rd = 9; d_rw = 1;
        tick(); clear_dec(); rst = 1;
        @(negedge clk); chk("pre_rst_estart", 32'(e_start), 1);
        tick(); rst = 0;
        @(negedge clk);
        chk("mid_rst_pc", pc, 0); chk("mid_rst_mode", 32'(mode), 0);
        chk("mid_rst_estart", 32'(e_start), 0); chk("mid_rst_upd", 32'(ew_upd), 2);

        for (int c = 0; c < 3000; c++) begin
            tick();
            rst         = ($urandom_range(0, 199) == 0);
            ld_done     = ($urandom_range(0, 3) == 0);
            boot_ack    = ($urandom_range(0, 3) == 0);
            d_valid     = ($urandom_range(0, 5) != 0);
            d_rs        = 6'($urandom_range(0, 7));
            d_rt        = 6'($urandom_range(0, 7));
            d_rs_use    = $urandom_range(0, 1) == 1;
            d_rt_use    = $urandom_range(0, 1) == 1;
            d_rd        = 6'($urandom_range(0, 7));
            d_rw        = $urandom_range(0, 1) == 1;
            d_wait      = WAIT_W'($urandom_range(0, 3));
            d_jump      = ($urandom_range(0, 9) == 0);
            d_npc       = $urandom & 32'hffff_fffc;
            d_stop      = ($urandom_range(0, 59) == 0);
            e_busy      = ($urandom_range(0, 7) == 0);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom & 32'hffff_fffc;
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_rd       = 6'($urandom_range(0, 7));
        end
        tick();
        clear_all(); rst = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
